// File: rtl/wb_slave.sv
// Wishbone register slave for a bank of PWM/timer channels.
// Each channel owns four words: ctrl, period, divisor and duty cycle. Timer interrupt flags latch into bit 5 of ctrl.
module wb_slave #(
    parameter int num_ch    = 4,
    parameter int mem_width = 16,
    parameter int mem_depth = 4*num_ch,
    parameter int adr_width = 16
) (
    input  logic                 i_wb_clk,
    input  logic                 i_wb_rst,
    input  logic                 i_wb_cyc,
    input  logic                 i_wb_stb,
    input  logic                 i_wb_we,
    input  logic [num_ch-1:0]    irq_flag,
    input  logic [adr_width-1:0] i_wb_adr,
    input  logic [mem_width-1:0] i_wb_data,
    output logic                 o_wb_ack,
    output logic [mem_width-1:0] o_wb_data
);

    localparam int IDX_W = (mem_depth > 1) ? $clog2(mem_depth) : 1;
    localparam logic [adr_width:0]   DEPTH   = (adr_width+1)'(mem_depth);
    localparam logic [mem_width-1:0] IRQ_BIT = mem_width'(32);

    logic [mem_width-1:0] regfile  [mem_depth];
    logic [mem_width-1:0] reg_next [mem_depth];

    logic             req;
    logic             in_range;
    logic             access;
    logic [IDX_W-1:0] idx;

    assign req      = i_wb_cyc & i_wb_stb;
    assign in_range = ({1'b0, i_wb_adr} < DEPTH);
    assign access   = req & in_range;
    assign idx      = i_wb_adr[IDX_W-1:0];

    // Next value per word: a bus write replaces the word, and the irq set is ORed on top so the hardware set wins.
    for (genvar w = 0; w < mem_depth; w++) begin : g_word
        logic                 wr_hit;
        logic [mem_width-1:0] irq_set;

        assign wr_hit = access & i_wb_we & (idx == IDX_W'(w));

        if (((w % 4) == 0) && ((w / 4) < num_ch)) begin : g_ctrl
            assign irq_set = irq_flag[w/4] ? IRQ_BIT : '0;
        end else begin : g_plain
            assign irq_set = '0;
        end

        assign reg_next[w] = (wr_hit ? i_wb_data : regfile[w]) | irq_set;
    end

    always_ff @(posedge i_wb_clk) begin
        if (i_wb_rst) begin
            for (int i = 0; i < mem_depth; i++) begin
                regfile[i] <= '0;
            end
            o_wb_ack  <= 1'b0;
            o_wb_data <= '0;
        end else begin
            regfile  <= reg_next;
            o_wb_ack <= access;
            // A read beyond the register bank returns zero; writes and idle cycles hold the last read data.
            if (access && !i_wb_we) begin
                o_wb_data <= regfile[idx];
            end else if (req && !in_range && !i_wb_we) begin
                o_wb_data <= '0;
            end
        end
    end

endmodule

// File: tb/tb_wb_slave.sv
// Bench for wb_slave: directed steps plus a random phase, compared against a transaction-level register model.
module tb_wb_slave;

    logic        clk;
    logic        rst;
    logic        cyc;
    logic        stb;
    logic        we;
    logic [3:0]  irq;
    logic [15:0] adr;
    logic [15:0] wdata;
    logic        ack;
    logic [15:0] rdata;

    int checks = 0;
    int errors = 0;

    // Reference model state
    logic [15:0] m_mem [16];
    logic        m_ack;
    logic [15:0] m_data;

    logic [15:0] saved [16];

    wb_slave #(
        .num_ch   (4),
        .mem_width(16),
        .mem_depth(16),
        .adr_width(16)
    ) dut (
        .i_wb_clk (clk),
        .i_wb_rst (rst),
        .i_wb_cyc (cyc),
        .i_wb_stb (stb),
        .i_wb_we  (we),
        .irq_flag (irq),
        .i_wb_adr (adr),
        .i_wb_data(wdata),
        .o_wb_ack (ack),
        .o_wb_data(rdata)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    // Apply one bus cycle's worth of rules to the model at a rising edge.
    task automatic model_edge();
        bit hit;
        hit = cyc && stb && (adr < 16);
        if (rst) begin
            foreach (m_mem[i]) m_mem[i] = 16'h0000;
            m_ack  = 1'b0;
            m_data = 16'h0000;
        end else begin
            m_ack = hit;
            if (hit && !we) m_data = m_mem[adr];
            else if (cyc && stb && !hit && !we) m_data = 16'h0000;
            if (hit && we) m_mem[adr] = wdata;
            for (int ch = 0; ch < 4; ch++) begin
                if (irq[ch]) m_mem[4*ch] = m_mem[4*ch] | 16'h0020;
            end
        end
    endtask

    // Called at a falling edge: drive inputs, let one rising edge pass, check at the next falling edge.
    task automatic step(input logic r, input logic c, input logic s, input logic w,
                        input logic [15:0] a, input logic [15:0] d, input logic [3:0] q,
                        input string tag);
        rst = r; cyc = c; stb = s; we = w; adr = a; wdata = d; irq = q;
        @(posedge clk);
        model_edge();
        @(negedge clk);
        chk({tag, ".ack"}, 32'(ack), 32'(m_ack));
        chk({tag, ".rdata"}, 32'(rdata), 32'(m_data));
        for (int i = 0; i < 16; i++) begin
            chk($sformatf("%s.regfile[%0d]", tag, i), 32'(dut.regfile[i]), 32'(m_mem[i]));
        end
    endtask

    initial begin
        logic [15:0] d;
        rst = 1'b0; cyc = 1'b0; stb = 1'b0; we = 1'b0; adr = '0; wdata = '0; irq = '0;
        foreach (m_mem[i]) m_mem[i] = 16'h0000;
        m_ack = 1'b0;
        m_data = 16'h0000;
        @(negedge clk);

        // Reset with all inputs low, then release into an idle cycle
        step(1, 0, 0, 0, 16'd0, 16'h0000, 4'b0000, "reset");
        chk("reset.ack_const", 32'(ack), 32'h0);
        chk("reset.rdata_const", 32'(rdata), 32'h0000);
        step(0, 0, 0, 0, 16'd0, 16'h0000, 4'b0000, "post_reset_idle");

        // Back-to-back write sweep with no idle cycles
        for (int a = 0; a < 16; a++) begin
            d = 16'($urandom);
            step(0, 1, 1, 1, 16'(a), d, 4'b0000, $sformatf("wr_sweep%0d", a));
            chk($sformatf("wr_sweep%0d.value", a), 32'(dut.regfile[a]), 32'(d));
            chk($sformatf("wr_sweep%0d.ack1", a), 32'(ack), 32'h1);
        end

        // Write then immediate read of the same address
        for (int a = 0; a < 16; a++) begin
            d = 16'($urandom);
            step(0, 1, 1, 1, 16'(a), d, 4'b0000, $sformatf("wtr_w%0d", a));
            step(0, 1, 1, 0, 16'(a), 16'($urandom), 4'b0000, $sformatf("wtr_r%0d", a));
            chk($sformatf("wtr_r%0d.data", a), 32'(rdata), 32'(d));
        end

        // Out-of-range writes leave the bank intact; out-of-range read returns zero
        foreach (saved[i]) saved[i] = m_mem[i];
        step(0, 1, 1, 1, 16'd16, 16'hBEEF, 4'b0000, "oor_w16");
        chk("oor_w16.ack0", 32'(ack), 32'h0);
        step(0, 1, 1, 1, 16'd21, 16'hCAFE, 4'b0000, "oor_w21");
        chk("oor_w21.ack0", 32'(ack), 32'h0);
        for (int i = 0; i < 16; i++) begin
            chk($sformatf("oor.unchanged%0d", i), 32'(dut.regfile[i]), 32'(saved[i]));
        end
        step(0, 1, 1, 0, 16'd3, 16'h0000, 4'b0000, "pre_oor_read");
        step(0, 1, 1, 0, 16'hFFFF, 16'h0000, 4'b0000, "oor_read");
        chk("oor_read.zero", 32'(rdata), 32'h0000);

        // IRQ latch into channel 1 ctrl, then read it back
        step(0, 1, 1, 1, 16'd4, 16'h0000, 4'b0000, "irq_clear4");
        step(0, 0, 0, 0, 16'd0, 16'h0000, 4'b0010, "irq_pulse");
        step(0, 0, 0, 0, 16'd0, 16'h0000, 4'b0000, "irq_idle");
        step(0, 1, 1, 0, 16'd4, 16'h0000, 4'b0000, "irq_read4");
        chk("irq_read4.data", 32'(rdata), 32'h0020);
        chk("irq_read4.ack", 32'(ack), 32'h1);

        // Simultaneous ctrl write and irq: hardware set wins; a later write of 0 clears it
        step(0, 1, 1, 1, 16'd0, 16'h0000, 4'b0001, "irq_collide");
        chk("irq_collide.bit5", 32'(dut.regfile[0]), 32'h0020);
        step(0, 1, 1, 1, 16'd0, 16'h0000, 4'b0000, "irq_sw_clear");
        chk("irq_sw_clear.val", 32'(dut.regfile[0]), 32'h0000);
        step(0, 1, 1, 1, 16'd8, 16'h00DF, 4'b0100, "irq_collide8");

        // Idle: cyc low with a would-be write
        step(0, 1, 1, 1, 16'd0, 16'h1234, 4'b0000, "idle_prep");
        step(0, 0, 1, 1, 16'd0, 16'hFFFF, 4'b0000, "idle_cyc0");
        chk("idle_cyc0.reg0", 32'(dut.regfile[0]), 32'h1234);
        chk("idle_cyc0.ack0", 32'(ack), 32'h0);
        step(0, 1, 0, 1, 16'd0, 16'hFFFF, 4'b0000, "idle_stb0");

        // Reset interrupting a write with irq pending
        step(1, 1, 1, 1, 16'd5, 16'hAAAA, 4'b1111, "rst_during_wr");
        step(0, 1, 1, 0, 16'd5, 16'h0000, 4'b0000, "rst_first_read");

        // Random traffic
        for (int n = 0; n < 300; n++) begin
            step(($urandom_range(0, 39) == 0),
                 ($urandom_range(0, 3) != 0),
                 ($urandom_range(0, 3) != 0),
                 1'($urandom),
                 16'($urandom_range(0, 23)),
                 16'($urandom),
                 ($urandom_range(0, 5) == 0) ? 4'($urandom) : 4'b0000,
                 $sformatf("rnd%0d", n));
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
